seg7_digit_counter: RTL and testbench

Single-digit decimal run/stop counter that produces the 7-segment pattern consumed on the top-level `uo_out[6:0]` (`segments`) and `uo_out[7]` (dp).
- Sits directly upstream of the top-level output mapping.
- Takes raw push-buttons from `ui_in`; debounces them; divides the clock into a count tick.
- Counts up or down with a programmable wrap limit.
- Registers the segment encoding.

---
 rtl/seg7_digit_counter.sv | 192 +++++++++++++++++++
 tb/tb_seg7_digit_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_digit_counter.sv
// seg7_digit_counter
// Single-digit decimal run/stop counter that drives a 7-segment display.
// Two raw push-buttons are synchronized, debounced and edge-detected; the
// run button toggles between STOP and RUN, the clear button zeroes the
// count. While running, a prescaler divides the clock into a count tick and
// the digit counts up or down, wrapping at a programmable limit.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        design enable; when low every register holds
//   btn_run    raw button, press toggles run/stop
//   btn_clr    raw button, press clears the count
//   dir        0 = count up, 1 = count down (sampled at tick)
//   max_digit  wrap limit; values above 9 behave as 9
//   digit      current BCD value
//   segments   active-high {g,f,e,d,c,b,a} pattern for digit
//   dp         heartbeat, toggles on every tick
//   running    high while in RUN
//   wrap_pulse one-cycle pulse when the count wraps
module seg7_digit_counter #(
    parameter int TICK_DIV  = 10000000,
    parameter int DB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_run,
    input  logic       btn_clr,
    input  logic       dir,
    input  logic [3:0] max_digit,
    output logic [3:0] digit,
    output logic [6:0] segments,
    output logic       dp,
    output logic       running,
    output logic       wrap_pulse
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_next;
    logic [3:0]      digit_next;
    logic            dp_next;
    logic            wrap_next;
    logic [3:0]      limit;
    logic            tick;

    // Bit 0 is the run button, bit 1 the clear button.
    logic [1:0]      raw_btn;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      db_state;
    logic [1:0]      db_prev;
    logic [CW-1:0]   db_cnt [2];
    logic [1:0]      press;
    logic            run_pulse;
    logic            clr_pulse;

    assign raw_btn   = {btn_clr, btn_run};
    assign press     = db_state & ~db_prev;
    assign run_pulse = press[0];
    assign clr_pulse = press[1];
    assign running   = (state == RUN);

    // Button front end: two-flop synchronizer, then a debounce counter that
    // only accepts a new level after DB_CYCLES consecutive differing samples.
    // db_prev delays the debounced level by one cycle so that a rising edge
    // yields a single-cycle press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a   <= '0;
            sync_b   <= '0;
            db_state <= '0;
            db_prev  <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else if (ena) begin
            sync_a  <= raw_btn;
            sync_b  <= sync_a;
            db_prev <= db_state;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == db_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_state[i] <= sync_b[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Next-state logic for the run/stop state, prescaler and count. Clear
    // has priority over a coincident tick but never blocks a run toggle.
    always_comb begin
        limit      = (max_digit > 4'd9) ? 4'd9 : max_digit;
        tick       = (state == RUN) && (presc == PRESC_LAST);
        state_next = state;
        presc_next = presc;
        digit_next = digit;
        dp_next    = dp;
        wrap_next  = 1'b0;

        if (run_pulse) begin
            state_next = (state == RUN) ? STOP : RUN;
        end

        if (state == RUN) begin
            presc_next = tick ? '0 : presc + PW'(1);
        end

        if (clr_pulse) begin
            digit_next = 4'd0;
            presc_next = '0;
            dp_next    = 1'b0;
        end else if (tick) begin
            dp_next = ~dp;
            if (!dir) begin
                if (digit >= limit) begin
                    digit_next = 4'd0;
                    wrap_next  = 1'b1;
                end else begin
                    digit_next = digit + 4'd1;
                end
            end else begin
                // Counting down from a digit above a freshly lowered limit
                // snaps to the limit without flagging a wrap.
                if (digit == 4'd0) begin
                    digit_next = limit;
                    wrap_next  = 1'b1;
                end else if (digit > limit) begin
                    digit_next = limit;
                end else begin
                    digit_next = digit - 4'd1;
                end
            end
        end
    end

    function automatic logic [6:0] encode(input logic [3:0] value);
        case (value)
            4'd0:    encode = 7'h3F;
            4'd1:    encode = 7'h06;
            4'd2:    encode = 7'h5B;
            4'd3:    encode = 7'h4F;
            4'd4:    encode = 7'h66;
            4'd5:    encode = 7'h6D;
            4'd6:    encode = 7'h7D;
            4'd7:    encode = 7'h07;
            4'd8:    encode = 7'h7F;
            4'd9:    encode = 7'h6F;
            default: encode = 7'h00;
        endcase
    endfunction

    // State registers. Segments are encoded from digit_next so the pattern
    // changes in the same cycle as the digit. A disabled design holds all
    // state but never leaves wrap_pulse asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STOP;
            presc      <= '0;
            digit      <= 4'd0;
            dp         <= 1'b0;
            wrap_pulse <= 1'b0;
            segments   <= 7'h3F;
        end else if (ena) begin
            state      <= state_next;
            presc      <= presc_next;
            digit      <= digit_next;
            dp         <= dp_next;
            wrap_pulse <= wrap_next;
            segments   <= encode(digit_next);
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_digit_counter.sv
// tb_seg7_digit_counter
// Directed testbench for seg7_digit_counter with TICK_DIV=4, DB_CYCLES=3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg7_digit_counter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       btn_run;
    logic       btn_clr;
    logic       dir;
    logic [3:0] max_digit;
    logic [3:0] digit;
    logic [6:0] segments;
    logic       dp;
    logic       running;
    logic       wrap_pulse;

    int vectors;
    int miscompares;
    logic exp_dp;

    logic [6:0] seg_table [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_digit_counter #(
        .TICK_DIV (4),
        .DB_CYCLES(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .btn_run   (btn_run),
        .btn_clr   (btn_clr),
        .dir       (dir),
        .max_digit (max_digit),
        .digit     (digit),
        .segments  (segments),
        .dp        (dp),
        .running   (running),
        .wrap_pulse(wrap_pulse)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic run_v, input logic clr_v,
                                 input logic dir_v, input logic [3:0] max_v);
        btn_run   = run_v;
        btn_clr   = clr_v;
        dir       = dir_v;
        max_digit = max_v;
    endtask

    // Wait n falling edges, then expect the tick just taken to have produced
    // exp_digit and the given wrap flag; dp toggles on every tick.
    task automatic expectTick(input int n, input int exp_digit, input logic exp_wrap);
        repeat (n) @(negedge clk);
        exp_dp = ~exp_dp;
        checkOutput("tick_digit", 32'(digit), 32'(exp_digit));
        checkOutput("tick_segments", 32'(segments), 32'(seg_table[exp_digit]));
        checkOutput("tick_wrap", 32'(wrap_pulse), 32'(exp_wrap));
        checkOutput("tick_dp", 32'(dp), 32'(exp_dp));
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] bounce;
        vectors     = 0;
        miscompares = 0;
        exp_dp      = 1'b0;
        rst_n       = 1'b0;
        ena         = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd9);

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_digit", 32'(digit), 32'd0);
        checkOutput("rst_segments", 32'(segments), 32'h3F);
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_dp", 32'(dp), 32'd0);
        checkOutput("rst_wrap", 32'(wrap_pulse), 32'd0);

        // Idle with buttons released: nothing changes.
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle_digit", 32'(digit), 32'd0);
        checkOutput("idle_running", 32'(running), 32'd0);
        checkOutput("idle_segments", 32'(segments), 32'h3F);

        // Run press: running rises exactly 6 edges after first sample.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd9);
        repeat (5) @(negedge clk);
        checkOutput("run_latency_early", 32'(running), 32'd0);
        @(negedge clk);
        checkOutput("run_latency", 32'(running), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("pretick_digit", 32'(digit), 32'd0);
        expectTick(1, 1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd9);

        // Count up to 9 then wrap to 0.
        for (int k = 2; k <= 9; k++) begin
            expectTick(4, k, 1'b0);
        end
        expectTick(4, 0, 1'b1);

        // Count down with limit 5 from 0.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5);
        @(negedge clk);
        checkOutput("wrap_single_cycle", 32'(wrap_pulse), 32'd0);
        expectTick(3, 5, 1'b1);
        expectTick(4, 4, 1'b0);
        expectTick(4, 3, 1'b0);

        // Limit 12 behaves as 9.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd12);
        for (int k = 4; k <= 9; k++) begin
            expectTick(4, k, 1'b0);
        end
        expectTick(4, 0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            expectTick(4, k, 1'b0);
        end

        // Lowering the limit below the digit wraps on the next up tick.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd3);
        expectTick(4, 0, 1'b1);

        // Bouncing clear press: 2 high, 1 low, 2 high.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd9);
        bounce = 6'b011011;
        for (int i = 0; i < 6; i++) begin
            btn_clr = bounce[i];
            @(negedge clk);
        end
        exp_dp = ~exp_dp;
        expectTick(2, 2, 1'b0);

        // Clean clear press whose pulse lands on a tick.
        repeat (2) @(negedge clk);
        btn_clr = 1'b1;
        expectTick(2, 3, 1'b0);
        repeat (4) @(negedge clk);
        exp_dp = 1'b0;
        checkOutput("clr_digit", 32'(digit), 32'd0);
        checkOutput("clr_segments", 32'(segments), 32'h3F);
        checkOutput("clr_wrap", 32'(wrap_pulse), 32'd0);
        checkOutput("clr_dp", 32'(dp), 32'd0);
        checkOutput("clr_running", 32'(running), 32'd1);
        btn_clr = 1'b0;
        expectTick(4, 1, 1'b0);

        // Enable low freezes everything.
        ena = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("ena_digit", 32'(digit), 32'd1);
        checkOutput("ena_dp", 32'(dp), 32'd1);
        checkOutput("ena_running", 32'(running), 32'd1);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("ena_resume_digit", 32'(digit), 32'd1);
        expectTick(1, 2, 1'b0);

        // Asynchronous reset mid-count.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_digit", 32'(digit), 32'd0);
        checkOutput("arst_segments", 32'(segments), 32'h3F);
        checkOutput("arst_running", 32'(running), 32'd0);
        checkOutput("arst_dp", 32'(dp), 32'd0);
        checkOutput("arst_wrap", 32'(wrap_pulse), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_dp = 1'b0;

        // Limit 0: digit stays 0 and every tick wraps.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        repeat (5) @(negedge clk);
        checkOutput("l0_run_early", 32'(running), 32'd0);
        @(negedge clk);
        checkOutput("l0_run", 32'(running), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        expectTick(4, 0, 1'b1);
        expectTick(4, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
